// File: rtl/keccak_absorb_buffer.sv
// -----------------------------------------------------------------------------
// keccak_absorb_buffer
//
// Purpose:
//   Absorb-side block builder for a Keccak/SHA-3 core. Packs an incoming
//   byte stream (data/keep/last beats of DWIDTH bits) into a rate-sized
//   block buffer, applies FIPS 202 domain-separation padding to the final
//   block, and presents each complete block to the permutation controller.
//
//   Optional build macro: KECCAK_ABSORB_KEEP_CHECK_EN
//     When defined, adds a sticky error_o output. Any accepted beat whose
//     keep mask is non-contiguous, or zero without last, is dropped and sets
//     error_o. error_o is cleared by an honoured start_i.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start_i            pulse in IDLE: latch keccak_mode_i / rate_i, clear buffer
//   keccak_mode_i      0 SHA3-256, 1 SHA3-512, 2 SHAKE128, 3 SHAKE256
//   rate_i             rate in bits (multiple of 64)
//   s_data_i/s_keep_i  message beat, byte i at [8i+:8], keep contiguous from bit 0
//   s_last_i           final beat of the message
//   s_valid_i/s_ready_o  input beat handshake
//   block_o            block bytes 0..rate-1 at [8i+:8], bytes >= rate are zero
//   block_valid_o/block_ready_i  output block handshake
//   block_last_o       presented block is the padded final block
//   bytes_absorbed_o   byte fill level of the block being built
//   busy_o             high from start_i until the final block handshake
//   fsm_state          debug view of the FSM state (0 IDLE, 1 FILL, 2 EMIT)
//   error_o            (macro only) sticky malformed-keep flag
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. A source holds valid and its payload stable until that edge;
// valid never depends combinationally on ready in this block.
// -----------------------------------------------------------------------------
module keccak_absorb_buffer #(
    parameter int DWIDTH            = 256,
    parameter int MAX_RATE_BYTES    = 168,
    parameter int MODE_SEL_WIDTH    = 2,
    parameter int RATE_WIDTH        = 11,
    parameter int BYTE_ABSORB_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic [MODE_SEL_WIDTH-1:0]    keccak_mode_i,
    input  logic [RATE_WIDTH-1:0]        rate_i,
    input  logic [DWIDTH-1:0]            s_data_i,
    input  logic [DWIDTH/8-1:0]          s_keep_i,
    input  logic                         s_last_i,
    input  logic                         s_valid_i,
    output logic                         s_ready_o,
    output logic [1599:0]                block_o,
    output logic                         block_valid_o,
    output logic                         block_last_o,
    input  logic                         block_ready_i,
    output logic [BYTE_ABSORB_WIDTH-1:0] bytes_absorbed_o,
    output logic                         busy_o,
    output logic [1:0]                   fsm_state
`ifdef KECCAK_ABSORB_KEEP_CHECK_EN
    ,
    output logic                         error_o
`endif
);

    localparam int BEAT_BYTES = DWIDTH / 8;
    localparam int CNT_W      = $clog2(BEAT_BYTES + 1);
    localparam int IW         = $clog2(BEAT_BYTES);
    localparam int BAW        = BYTE_ABSORB_WIDTH;

    localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHAKE128 = MODE_SEL_WIDTH'(2);
    localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHAKE256 = MODE_SEL_WIDTH'(3);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [MAX_RATE_BYTES*8-1:0]   blk_q, blk_d;
    logic [DWIDTH-1:0]             spill_q, spill_d;
    logic [CNT_W-1:0]              spill_cnt_q, spill_cnt_d;
    logic                          spill_last_q, spill_last_d;
    logic [BAW-1:0]                fill_q, fill_d;
    logic                          last_q, last_d;
    logic [BAW-1:0]                rate_q;
    logic [MODE_SEL_WIDTH-1:0]     mode_q;

    logic                          beat_fire;
    logic                          beat_bad;
    logic [CNT_W-1:0]              keep_cnt;
    logic [BAW:0]                  fill_sum;
    logic [DWIDTH-1:0]             spill_beat;
    logic [7:0]                    suffix;

    // Buffer write port shared by the FILL path (beat into current block)
    // and the EMIT path (spill bytes into a freshly cleared block).
    logic                          wr_en;
    logic                          wr_clear;
    logic                          wr_pad;
    logic [DWIDTH-1:0]             wr_src;
    logic [BAW-1:0]                wr_off;
    logic [CNT_W-1:0]              wr_n;

    int                            kb;
    int                            ks;

    assign beat_fire = s_valid_i && s_ready_o;
    assign fill_sum  = {1'b0, fill_q} + (BAW+1)'(keep_cnt);
    assign suffix    = (mode_q == MODE_SHAKE128 || mode_q == MODE_SHAKE256) ? 8'h1F : 8'h06;

`ifdef KECCAK_ABSORB_KEEP_CHECK_EN
    // A well-formed mask is 2^k-1: adding one clears every set bit.
    assign beat_bad = ((s_keep_i & (s_keep_i + 1'b1)) != '0) ||
                      (s_keep_i == '0 && !s_last_i);
`else
    assign beat_bad = 1'b0;
`endif

    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            keep_cnt = keep_cnt + CNT_W'(s_keep_i[i]);
        end
    end

    // Overflow bytes of a beat that crosses the rate boundary, realigned to 0.
    always_comb begin
        spill_beat = '0;
        ks         = 0;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            ks = int'(rate_q) - int'(fill_q) + i;
            if (ks >= 0 && ks < int'(keep_cnt)) begin
                spill_beat[8*i +: 8] = s_data_i[{ks[IW-1:0], 3'b000} +: 8];
            end
        end
    end

    // Next-state and control
    always_comb begin
        state_d      = state_q;
        fill_d       = fill_q;
        last_d       = last_q;
        spill_d      = spill_q;
        spill_cnt_d  = spill_cnt_q;
        spill_last_d = spill_last_q;
        wr_en        = 1'b0;
        wr_clear     = 1'b0;
        wr_pad       = 1'b0;
        wr_src       = s_data_i;
        wr_off       = fill_q;
        wr_n         = keep_cnt;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d      = ST_FILL;
                    wr_clear     = 1'b1;
                    fill_d       = '0;
                    last_d       = 1'b0;
                    spill_d      = '0;
                    spill_cnt_d  = '0;
                    spill_last_d = 1'b0;
                end
            end
            ST_FILL: begin
                if (beat_fire && !beat_bad) begin
                    wr_en = 1'b1;
                    if (fill_sum >= {1'b0, rate_q}) begin
                        // Block full. An exact fit with last leaves an empty
                        // spill that still carries last, which later yields
                        // the padding-only block.
                        state_d      = ST_EMIT;
                        last_d       = 1'b0;
                        fill_d       = rate_q;
                        spill_d      = spill_beat;
                        spill_cnt_d  = CNT_W'(fill_sum - {1'b0, rate_q});
                        spill_last_d = s_last_i;
                    end else if (s_last_i) begin
                        wr_pad  = 1'b1;
                        state_d = ST_EMIT;
                        last_d  = 1'b1;
                        fill_d  = fill_sum[BAW-1:0];
                    end else begin
                        fill_d = fill_sum[BAW-1:0];
                    end
                end
            end
            ST_EMIT: begin
                if (block_ready_i) begin
                    wr_clear     = 1'b1;
                    spill_d      = '0;
                    spill_cnt_d  = '0;
                    spill_last_d = 1'b0;
                    if (last_q) begin
                        state_d = ST_IDLE;
                        fill_d  = '0;
                        last_d  = 1'b0;
                    end else begin
                        wr_en  = 1'b1;
                        wr_src = spill_q;
                        wr_off = '0;
                        wr_n   = spill_cnt_q;
                        fill_d = BAW'(spill_cnt_q);
                        if (spill_last_q) begin
                            // Final padding straight away; stay in EMIT.
                            wr_pad = 1'b1;
                            last_d = 1'b1;
                        end else begin
                            state_d = ST_FILL;
                            last_d  = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Buffer datapath: optional clear, byte write at wr_off, optional padding
    // at wr_off+wr_n and on byte rate-1 (OR so they merge into 0x86/0x9F).
    always_comb begin
        blk_d = wr_clear ? '0 : blk_q;
        kb    = 0;
        for (int j = 0; j < MAX_RATE_BYTES; j++) begin
            kb = j - int'(wr_off);
            if (wr_en && kb >= 0 && kb < int'(wr_n) && j < int'(rate_q)) begin
                blk_d[8*j +: 8] = wr_src[{kb[IW-1:0], 3'b000} +: 8];
            end
            if (wr_pad && j == int'(wr_off) + int'(wr_n)) begin
                blk_d[8*j +: 8] = blk_d[8*j +: 8] | suffix;
            end
            if (wr_pad && j == int'(rate_q) - 1) begin
                blk_d[8*j +: 8] = blk_d[8*j +: 8] | 8'h80;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            blk_q        <= '0;
            spill_q      <= '0;
            spill_cnt_q  <= '0;
            spill_last_q <= 1'b0;
            fill_q       <= '0;
            last_q       <= 1'b0;
            rate_q       <= '0;
            mode_q       <= '0;
        end else begin
            state_q      <= state_d;
            blk_q        <= blk_d;
            spill_q      <= spill_d;
            spill_cnt_q  <= spill_cnt_d;
            spill_last_q <= spill_last_d;
            fill_q       <= fill_d;
            last_q       <= last_d;
            if (state_q == ST_IDLE && start_i) begin
                mode_q <= keccak_mode_i;
                rate_q <= BAW'(rate_i >> 3);
            end
        end
    end

`ifdef KECCAK_ABSORB_KEEP_CHECK_EN
    logic error_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_q <= 1'b0;
        end else if (state_q == ST_IDLE && start_i) begin
            error_q <= 1'b0;
        end else if (beat_fire && beat_bad) begin
            error_q <= 1'b1;
        end
    end

    assign error_o = error_q;
`endif

    assign s_ready_o        = (state_q == ST_FILL) && (spill_cnt_q == '0) && !spill_last_q;
    assign block_valid_o    = (state_q == ST_EMIT);
    assign block_last_o     = last_q;
    assign block_o          = {{(1600 - MAX_RATE_BYTES*8){1'b0}}, blk_q};
    assign bytes_absorbed_o = fill_q;
    assign busy_o           = (state_q != ST_IDLE);
    assign fsm_state        = state_q;

endmodule

// File: tb/tb_keccak_absorb_buffer.sv
// -----------------------------------------------------------------------------
// tb_keccak_absorb_buffer
//
// Self-checking bench for keccak_absorb_buffer. Expected blocks come from a
// FIPS 202 padding model: the whole message is padded as one byte array
// (message, suffix byte, zeros, final byte |= 0x80, length a multiple of the
// rate) and then cut into rate-sized blocks.
// -----------------------------------------------------------------------------
module tb_keccak_absorb_buffer;

    localparam int BB = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic [1:0]    keccak_mode_i = '0;
    logic [10:0]   rate_i = '0;
    logic [255:0]  s_data_i = '0;
    logic [31:0]   s_keep_i = '0;
    logic          s_last_i = 1'b0;
    logic          s_valid_i = 1'b0;
    logic          s_ready_o;
    logic [1599:0] block_o;
    logic          block_valid_o;
    logic          block_last_o;
    logic          block_ready_i = 1'b0;
    logic [7:0]    bytes_absorbed_o;
    logic          busy_o;
    logic [1:0]    fsm_state;
`ifdef KECCAK_ABSORB_KEEP_CHECK_EN
    logic          error_o;
`endif

    int            n_checks = 0;
    int            n_errors = 0;
    logic [1600:0] exp_q[$];
    bit            hold_ready = 1'b0;

    keccak_absorb_buffer dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start_i),
        .keccak_mode_i    (keccak_mode_i),
        .rate_i           (rate_i),
        .s_data_i         (s_data_i),
        .s_keep_i         (s_keep_i),
        .s_last_i         (s_last_i),
        .s_valid_i        (s_valid_i),
        .s_ready_o        (s_ready_o),
        .block_o          (block_o),
        .block_valid_o    (block_valid_o),
        .block_last_o     (block_last_o),
        .block_ready_i    (block_ready_i),
        .bytes_absorbed_o (bytes_absorbed_o),
        .busy_o           (busy_o),
        .fsm_state        (fsm_state)
`ifdef KECCAK_ABSORB_KEEP_CHECK_EN
        ,
        .error_o          (error_o)
`endif
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int rate_bytes(input int mode);
        case (mode)
            0:       return 136;
            1:       return 72;
            2:       return 168;
            default: return 136;
        endcase
    endfunction

    // Reference model: pad the whole message, then split into blocks.
    task automatic model(input int mode, input int rb, input logic [7:0] msg[$]);
        logic [7:0]    p[];
        logic [1600:0] e;
        int            len;
        int            nb;
        len = msg.size();
        nb  = len / rb + 1;
        p   = new[nb * rb];
        foreach (p[i]) p[i] = 8'h00;
        foreach (msg[i]) p[i] = msg[i];
        p[len] = (mode >= 2) ? 8'h1F : 8'h06;
        p[nb*rb-1] = p[nb*rb-1] | 8'h80;
        for (int b = 0; b < nb; b++) begin
            e = '0;
            for (int i = 0; i < rb; i++) e[8*i +: 8] = p[b*rb + i];
            e[1600] = (b == nb - 1);
            exp_q.push_back(e);
        end
    endtask

    // Scoreboard side: compare the block being handed over against the queue.
    task automatic take_block();
        logic [1663:0] g;
        logic [1663:0] e;
        int            idx;
        g = 1664'({block_last_o, block_o});
        if (exp_q.size() == 0) begin
            check("unexpected_block", 64'(block_valid_o), 64'd0);
            return;
        end
        e   = 1664'(exp_q.pop_front());
        idx = 0;
        for (int w = 25; w >= 0; w--) begin
            if (g[64*w +: 64] !== e[64*w +: 64]) idx = w;
        end
        check($sformatf("block_word%0d", idx), g[64*idx +: 64], e[64*idx +: 64]);
    endtask

    // Consumer: random block_ready_i, decided at negedge, unless held.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) block_ready_i = 1'b0;
            else     block_ready_i = !hold_ready && ($urandom_range(0, 1) == 1);
            if (block_valid_o && block_ready_i) take_block();
        end
    end

    // ---------------- drivers (called and returning at negedge) ----------------
    task automatic do_start(input int mode);
        start_i       = 1'b1;
        keccak_mode_i = 2'(mode);
        rate_i        = 11'(rate_bytes(mode) * 8);
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input logic l);
        int t;
        t         = 0;
        s_data_i  = d;
        s_keep_i  = k;
        s_last_i  = l;
        s_valid_i = 1'b1;
        while (!s_ready_o && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) check("beat_accept_timeout", 64'(s_ready_o), 64'd1);
        @(negedge clk);
        s_valid_i = 1'b0;
        s_keep_i  = '0;
        s_last_i  = 1'b0;
    endtask

    task automatic send_msg(input int mode, input logic [7:0] msg[$], input bit rnd);
        int           rb;
        int           s;
        int           n;
        bit           last;
        logic [255:0] d;
        logic [31:0]  k;
        rb = rate_bytes(mode);
        model(mode, rb, msg);
        do_start(mode);
        s = 0;
        do begin
            n = rnd ? int'($urandom_range(1, BB)) : BB;
            if (n > msg.size() - s) n = msg.size() - s;
            last = (s + n == msg.size());
            d = '0;
            k = '0;
            for (int i = 0; i < BB; i++) begin
                if (i < n) begin
                    d[8*i +: 8] = msg[s + i];
                    k[i]        = 1'b1;
                end else if (rnd) begin
                    d[8*i +: 8] = 8'($urandom);
                end
            end
            send_beat(d, k, last);
            if (((s % rb) + n >= rb) || last) begin
                check("valid_latency", 64'(block_valid_o), 64'd1);
            end else begin
                check("valid_latency", 64'(block_valid_o), 64'd0);
                check("fill_level", 64'(bytes_absorbed_o), 64'((s + n) % rb));
            end
            s += n;
            if (rnd && !last) repeat ($urandom_range(0, 2)) @(negedge clk);
        end while (!last);
    endtask

    task automatic wait_valid();
        int t;
        t = 0;
        while (!block_valid_o && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("wait_valid", 64'(block_valid_o), 64'd1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy_o && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("idle", 64'(busy_o), 64'd0);
        check("exp_drained", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0]   msg[$];
        logic [255:0] d;
        int           mode;
        int           len;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_s_ready", 64'(s_ready_o), 64'd0);
        check("rst_valid", 64'(block_valid_o), 64'd0);
        check("rst_last", 64'(block_last_o), 64'd0);
        check("rst_fill", 64'(bytes_absorbed_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_block", 64'(|block_o), 64'd0);
        check("rst_state", 64'(fsm_state), 64'd0);
`ifdef KECCAK_ABSORB_KEEP_CHECK_EN
        check("rst_error", 64'(error_o), 64'd0);
`endif

        // Beats in IDLE are not accepted
        s_valid_i = 1'b1;
        s_keep_i  = 32'hF;
        @(negedge clk);
        check("idle_s_ready", 64'(s_ready_o), 64'd0);
        check("idle_busy", 64'(busy_o), 64'd0);
        s_valid_i = 1'b0;
        s_keep_i  = '0;
        @(negedge clk);

        // SHA3-256 "abc"
        hold_ready = 1'b1;
        msg = {8'h61, 8'h62, 8'h63};
        send_msg(0, msg, 1'b0);
        wait_valid();
        check("abc_bytes", 64'(block_o[23:0]), 64'h636261);
        check("abc_pad", 64'(block_o[31:24]), 64'h06);
        check("abc_end", 64'(block_o[8*135 +: 8]), 64'h80);
        check("abc_mid_zero", 64'(|block_o[8*135-1:32]), 64'd0);
        check("abc_high_zero", 64'(|block_o[1599:8*136]), 64'd0);
        check("abc_last", 64'(block_last_o), 64'd1);
        hold_ready = 1'b0;
        wait_idle();

        // SHA3-512: three full beats, spill of 24 bytes carrying last
        msg = {};
        for (int i = 0; i < 96; i++) msg.push_back(8'($urandom));
        send_msg(1, msg, 1'b0);
        wait_idle();

        // SHAKE128: 168 bytes exactly on the rate
        msg = {};
        for (int i = 0; i < 168; i++) msg.push_back(8'($urandom));
        send_msg(2, msg, 1'b0);
        wait_idle();

        // SHA3-256: 135 bytes -> merged 0x86 pad byte
        hold_ready = 1'b1;
        msg = {};
        for (int i = 0; i < 135; i++) msg.push_back(8'($urandom));
        send_msg(0, msg, 1'b0);
        wait_valid();
        check("len135_pad", 64'(block_o[8*135 +: 8]), 64'h86);
        check("len135_last", 64'(block_last_o), 64'd1);
        hold_ready = 1'b0;
        wait_idle();

        // Empty message with 5 cycles of backpressure
        hold_ready = 1'b1;
        msg = {};
        send_msg(0, msg, 1'b0);
        wait_valid();
        check("empty_byte0", 64'(block_o[7:0]), 64'h06);
        check("empty_byte135", 64'(block_o[8*135 +: 8]), 64'h80);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (exp_q.size() > 0)
                check("bp_block_stable", 64'(block_o == exp_q[0][1599:0]), 64'd1);
            else
                check("bp_exp_present", 64'(exp_q.size()), 64'd1);
            check("bp_valid", 64'(block_valid_o), 64'd1);
            check("bp_s_ready", 64'(s_ready_o), 64'd0);
        end
        hold_ready = 1'b0;
        wait_idle();

        // Reset in the middle of FILL after 40 bytes
        do_start(0);
        d = {8{32'($urandom)}};
        send_beat(d, 32'hFFFF_FFFF, 1'b0);
        send_beat(d, 32'h0000_00FF, 1'b0);
        check("pre_rst_fill", 64'(bytes_absorbed_o), 64'd40);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", 64'(busy_o), 64'd0);
        check("mid_rst_fill", 64'(bytes_absorbed_o), 64'd0);
        check("mid_rst_s_ready", 64'(s_ready_o), 64'd0);
        check("mid_rst_valid", 64'(block_valid_o), 64'd0);
        check("mid_rst_block", 64'(|block_o), 64'd0);
        check("mid_rst_state", 64'(fsm_state), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

`ifdef KECCAK_ABSORB_KEEP_CHECK_EN
        // Non-contiguous keep is dropped and flagged
        do_start(0);
        d = {8{32'($urandom)}};
        send_beat(d, 32'h5, 1'b0);
        check("err_set", 64'(error_o), 64'd1);
        check("err_dropped", 64'(bytes_absorbed_o), 64'd0);
        msg = {8'h61, 8'h62, 8'h63};
        model(0, 136, msg);
        send_beat(256'h636261, 32'h7, 1'b1);
        wait_idle();
        check("err_sticky", 64'(error_o), 64'd1);
        msg = {};
        model(0, 136, msg);
        do_start(0);
        check("err_cleared", 64'(error_o), 64'd0);
        send_beat('0, 32'h0, 1'b1);
        wait_idle();
`endif

        // Randomised messages, random beat sizes and modes
        for (int m = 0; m < 14; m++) begin
            mode = int'($urandom_range(0, 3));
            len  = int'($urandom_range(0, 350));
            msg  = {};
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            send_msg(mode, msg, 1'b1);
            wait_idle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
